// File: rtl/rr_mux_reg_pkg.sv
// Shared definitions for the registered round-robin selector.
// Mode encodings and select-width helper.
package rr_mux_reg_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first requester after ptr, wrapping.
// Purely combinational.
module rr_priority_pick #(
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  int idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (req[idx]) begin
        grant       = idx[SEL_W-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// Registered N-to-1 selector, fixed or round-robin,
// with a one-entry valid/ready output register.
module rr_mux_reg
  import rr_mux_reg_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load_en;

  rr_priority_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req         (in_valid),
    .ptr         (ptr),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  assign load_en = !out_valid || out_ready;

  // Out-of-range sel never grants.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    unique case (mode)
      MODE_RR: begin
        grant       = rr_grant;
        grant_valid = rr_valid;
      end
      default: begin
        grant       = sel;
        grant_valid = (int'(sel) < NUM_IN) && in_valid[sel];
      end
    endcase
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = !reset && load_en && grant_valid
                    && (int'(grant) == i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= SEL_W'(NUM_IN - 1);
    end else if (load_en) begin
      if (grant_valid) begin
        out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
        out_src   <= grant;
        out_valid <= 1'b1;
        if (mode == MODE_RR) ptr <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Self-checking bench: 8x32 and 5x16 instances against a
// behavioural model, directed steps then random traffic.
module tb_rr_mux_reg;

  logic clock = 1'b0;
  logic reset;

  logic [255:0] a_in_data;
  logic [7:0]   a_in_valid, a_in_ready;
  logic         a_mode;
  logic [2:0]   a_sel;
  logic [31:0]  a_out_data;
  logic [2:0]   a_out_src;
  logic         a_out_valid, a_out_ready;

  logic [79:0]  b_in_data;
  logic [4:0]   b_in_valid, b_in_ready;
  logic         b_mode;
  logic [2:0]   b_sel;
  logic [15:0]  b_out_data;
  logic [2:0]   b_out_src;
  logic         b_out_valid, b_out_ready;

  logic [31:0] a_w [8];
  logic [15:0] b_w [5];

  int checks = 0;
  int errors = 0;

  logic        ma_valid = 1'b0;
  logic [31:0] ma_data  = '0;
  int          ma_src   = 0;
  int          ma_ptr   = 7;
  logic        mb_valid = 1'b0;
  logic [15:0] mb_data  = '0;
  int          mb_src   = 0;
  int          mb_ptr   = 4;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < 8; i++) a_in_data[i*32 +: 32] = a_w[i];
    for (int i = 0; i < 5; i++) b_in_data[i*16 +: 16] = b_w[i];
  end

  rr_mux_reg #(.WIDTH(32), .NUM_IN(8)) dut_a (
    .clock     (clock),
    .reset     (reset),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .mode      (a_mode),
    .sel       (a_sel),
    .out_data  (a_out_data),
    .out_src   (a_out_src),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  rr_mux_reg #(.WIDTH(16), .NUM_IN(5)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .mode      (b_mode),
    .sel       (b_sel),
    .out_data  (b_out_data),
    .out_src   (b_out_src),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  // Who should win: sel in fixed mode, else first valid after p.
  function automatic int pick(input int n, input logic [7:0] v,
                              input logic m, input int s,
                              input int p, output logic gv);
    if (!m) begin
      gv = (s < n) && v[s];
      return s;
    end
    for (int k = 1; k <= n; k++) begin
      if (v[(p + k) % n]) begin
        gv = 1'b1;
        return (p + k) % n;
      end
    end
    gv = 1'b0;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic ga, gb, lea, leb;
    int   xa, xb;
    @(negedge clock);
    lea = !ma_valid || a_out_ready;
    leb = !mb_valid || b_out_ready;
    xa = pick(8, a_in_valid, a_mode, int'(a_sel), ma_ptr, ga);
    xb = pick(5, {3'b000, b_in_valid}, b_mode, int'(b_sel),
              mb_ptr, gb);
    chk("a_in_ready", 64'(a_in_ready),
        (reset || !lea || !ga) ? 64'd0 : (64'd1 << xa));
    chk("b_in_ready", 64'(b_in_ready),
        (reset || !leb || !gb) ? 64'd0 : (64'd1 << xb));
    @(posedge clock);
    if (reset) begin
      ma_valid = 1'b0; ma_data = '0; ma_src = 0; ma_ptr = 7;
      mb_valid = 1'b0; mb_data = '0; mb_src = 0; mb_ptr = 4;
    end else begin
      if (lea) begin
        ma_valid = ga;
        if (ga) begin
          ma_data = a_w[xa];
          ma_src  = xa;
          if (a_mode) ma_ptr = xa;
        end
      end
      if (leb) begin
        mb_valid = gb;
        if (gb) begin
          mb_data = b_w[xb];
          mb_src  = xb;
          if (b_mode) mb_ptr = xb;
        end
      end
    end
    #1;
    chk("a_out_valid", 64'(a_out_valid), 64'(ma_valid));
    chk("b_out_valid", 64'(b_out_valid), 64'(mb_valid));
    if (ma_valid) begin
      chk("a_out_data", 64'(a_out_data), 64'(ma_data));
      chk("a_out_src", 64'(a_out_src), 64'(ma_src));
    end
    if (mb_valid) begin
      chk("b_out_data", 64'(b_out_data), 64'(mb_data));
      chk("b_out_src", 64'(b_out_src), 64'(mb_src));
    end
  endtask

  initial begin
    reset       = 1'b1;
    a_mode      = 1'b1;
    b_mode      = 1'b1;
    a_sel       = '0;
    b_sel       = '0;
    a_in_valid  = 8'hFF;
    b_in_valid  = 5'h1F;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) a_w[i] = 32'(i);
    for (int i = 0; i < 5; i++) b_w[i] = 16'(i);

    // reset with everything valid
    tick();
    tick();
    chk("rst_a_data", 64'(a_out_data), 64'd0);
    chk("rst_a_src", 64'(a_out_src), 64'd0);
    chk("rst_b_data", 64'(b_out_data), 64'd0);
    chk("rst_a_ready", 64'(a_in_ready), 64'd0);

    // round-robin fairness, both instances
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("a_rr_seq", 64'(a_out_src), 64'(i % 8));
      chk("b_rr_seq", 64'(b_out_src), 64'(i % 5));
      chk("a_rr_valid", 64'(a_out_valid), 64'd1);
    end

    // fixed mode; b gets an out-of-range sel
    a_mode     = 1'b0;
    a_sel      = 3'd5;
    a_in_valid = 8'b0010_0000;
    a_w[5]     = 32'hDEADBEEF;
    b_mode     = 1'b0;
    b_sel      = 3'd6;
    tick();
    chk("fix_data", 64'(a_out_data), 64'hDEADBEEF);
    chk("fix_src", 64'(a_out_src), 64'd5);
    chk("fix_ready", 64'(a_in_ready), 64'b0010_0000);
    chk("oor_ready", 64'(b_in_ready), 64'd0);
    chk("oor_valid", 64'(b_out_valid), 64'd0);
    a_in_valid = 8'h00;
    tick();
    chk("fix_drop", 64'(a_out_valid), 64'd0);

    // b back to round robin: restarts after last grant 4
    b_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("b_rr_wrap", 64'(b_out_src), 64'(i % 5));
    end

    // a: set ptr to 7, then alternate 1,7
    a_mode     = 1'b1;
    a_in_valid = 8'h80;
    tick();
    chk("a_ptr7", 64'(a_out_src), 64'd7);
    a_in_valid = 8'b1000_0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("a_alt", 64'(a_out_src), (i % 2 == 0) ? 64'd1 : 64'd7);
    end

    // back-pressure holds input 7's word
    a_in_valid  = 8'hFF;
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_data", 64'(a_out_data), 64'd7);
      chk("bp_ready", 64'(a_in_ready), 64'd0);
    end
    a_out_ready = 1'b1;
    a_in_valid  = 8'b0000_1000;
    tick();
    chk("pop_load_src", 64'(a_out_src), 64'd3);
    chk("pop_load_v", 64'(a_out_valid), 64'd1);

    // reset while stalled
    a_in_valid  = 8'hFF;
    a_out_ready = 1'b0;
    reset       = 1'b1;
    tick();
    chk("rst_stall", 64'(a_out_valid), 64'd0);
    reset       = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("rst_restart", 64'(a_out_src), 64'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      reset       = (($urandom % 64) == 0);
      a_in_valid  = 8'($urandom);
      a_mode      = 1'($urandom);
      a_sel       = 3'($urandom);
      a_out_ready = (($urandom % 4) != 0);
      b_in_valid  = 5'($urandom);
      b_mode      = 1'($urandom);
      b_sel       = 3'($urandom);
      b_out_ready = (($urandom % 4) != 0);
      for (int i = 0; i < 8; i++) a_w[i] = $urandom;
      for (int i = 0; i < 5; i++) b_w[i] = 16'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
